syncword_correlator: RTL and testbench

SYNCWORD_CORRELATOR -- requirements
Module: syncword_correlator

---
 rtl/syncword_correlator.sv | 114 +++++++++++
 tb/tb_syncword_correlator.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syncword_correlator.sv
// Sliding 64-bit sync word correlator with error threshold, trailer check and
// ID-packet detection, driven by a 1 us bit strobe in the 6 MHz clock domain.
module syncword_correlator (
    input  logic        clk_6M,
    input  logic        rstz,
    input  logic        p_1us,
    input  logic        rxbit,
    input  logic        rx_window,
    input  logic        corr_clear,
    input  logic        id_mode,
    input  logic [63:0] regi_syncword,
    input  logic [3:0]  regi_corr_threshold,
    output logic        rx_trailer_st_p,
    output logic        id_rcv_p,
    output logic        sync_found,
    output logic [6:0]  sync_errcnt,
    output logic        trailer_err,
    output logic [7:0]  detect_cnt
);

    typedef enum logic [1:0] {IDLE, SEARCH, TRAILER, LOCKED} state_t;

    state_t      state;
    logic [63:0] sr;
    logic [6:0]  fill;
    logic [1:0]  tcnt;
    logic [6:0]  errs;
    logic        match;
    logic        detect;
    logic        trl_exp;

    function automatic logic [6:0] popcount64(input logic [63:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) begin
            c = c + 7'(v[i]);
        end
        return c;
    endfunction

    assign errs  = popcount64(sr ^ regi_syncword);
    assign match = (fill == 7'd64) && (errs <= {3'd0, regi_corr_threshold});

    // Pulses are combinational so they coincide with the strobe that detects;
    // an abort in the same cycle suppresses them.
    assign detect          = (state == SEARCH) && p_1us && match && rx_window && !corr_clear;
    assign rx_trailer_st_p = detect && !id_mode;
    assign id_rcv_p        = detect && id_mode;
    assign sync_found      = (state == TRAILER) || (state == LOCKED);

    // Trailer alternates starting with the complement of the last sync bit.
    assign trl_exp = tcnt[0] ? regi_syncword[0] : ~regi_syncword[0];

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state       <= IDLE;
            sr          <= '0;
            fill        <= '0;
            tcnt        <= '0;
            sync_errcnt <= '0;
            trailer_err <= 1'b0;
            detect_cnt  <= '0;
        end else if (corr_clear || !rx_window) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state       <= SEARCH;
                    sr          <= '0;
                    fill        <= '0;
                    tcnt        <= '0;
                    trailer_err <= 1'b0;
                end
                SEARCH: begin
                    if (p_1us) begin
                        if (match) begin
                            sync_errcnt <= errs;
                            if (detect_cnt != 8'hFF) begin
                                detect_cnt <= detect_cnt + 8'd1;
                            end
                            if (id_mode) begin
                                state <= LOCKED;
                            end else begin
                                // The bit arriving with the detection is trailer bit 0.
                                trailer_err <= trailer_err | (rxbit != trl_exp);
                                tcnt        <= 2'd1;
                                state       <= TRAILER;
                            end
                        end else begin
                            sr <= {sr[62:0], rxbit};
                            if (fill != 7'd64) begin
                                fill <= fill + 7'd1;
                            end
                        end
                    end
                end
                TRAILER: begin
                    if (p_1us) begin
                        trailer_err <= trailer_err | (rxbit != trl_exp);
                        tcnt        <= tcnt + 2'd1;
                        if (tcnt == 2'd3) begin
                            state <= LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    state <= LOCKED;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_syncword_correlator.sv
// Directed testbench for syncword_correlator: exact/threshold detection, ID
// mode, trailer checking, aborts, counter saturation and asynchronous reset.
module tb_syncword_correlator;

    localparam logic [63:0] SW   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] FLIP = 64'h8000_0000_1000_0001;

    logic        clk_6M;
    logic        rstz;
    logic        p_1us;
    logic        rxbit;
    logic        rx_window;
    logic        corr_clear;
    logic        id_mode;
    logic [63:0] regi_syncword;
    logic [3:0]  regi_corr_threshold;
    logic        rx_trailer_st_p;
    logic        id_rcv_p;
    logic        sync_found;
    logic [6:0]  sync_errcnt;
    logic        trailer_err;
    logic [7:0]  detect_cnt;

    int checks   = 0;
    int failures = 0;
    int gap      = 2;
    int trl_cnt  = 0;
    int id_cnt   = 0;
    int both_cnt = 0;
    logic s_trl;
    logic s_id;

    syncword_correlator dut (
        .clk_6M              (clk_6M),
        .rstz                (rstz),
        .p_1us               (p_1us),
        .rxbit               (rxbit),
        .rx_window           (rx_window),
        .corr_clear          (corr_clear),
        .id_mode             (id_mode),
        .regi_syncword       (regi_syncword),
        .regi_corr_threshold (regi_corr_threshold),
        .rx_trailer_st_p     (rx_trailer_st_p),
        .id_rcv_p            (id_rcv_p),
        .sync_found          (sync_found),
        .sync_errcnt         (sync_errcnt),
        .trailer_err         (trailer_err),
        .detect_cnt          (detect_cnt)
    );

    initial begin
        clk_6M = 1'b0;
        forever #5 clk_6M = ~clk_6M;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk_6M) begin
        if (rx_trailer_st_p) trl_cnt++;
        if (id_rcv_p) id_cnt++;
        if (rx_trailer_st_p && id_rcv_p) both_cnt++;
    end

    task automatic send_bit(input logic b);
        p_1us = 1'b1;
        rxbit = b;
        #2;
        s_trl = rx_trailer_st_p;
        s_id  = id_rcv_p;
        @(posedge clk_6M); #1;
        p_1us = 1'b0;
        repeat (gap) begin
            @(posedge clk_6M); #1;
        end
    endtask

    task automatic send_word(input logic [63:0] w);
        for (int i = 63; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic open_window();
        rx_window = 1'b1;
        @(posedge clk_6M); #1;
    endtask

    task automatic close_window();
        rx_window = 1'b0;
        @(posedge clk_6M); #1;
    endtask

    task automatic test_reset();
        rstz = 1'b0; p_1us = 1'b0; rxbit = 1'b0; rx_window = 1'b0;
        corr_clear = 1'b0; id_mode = 1'b0;
        regi_syncword = SW; regi_corr_threshold = 4'd0;
        repeat (2) @(posedge clk_6M);
        #1;
        checks++;
        if ({rx_trailer_st_p, id_rcv_p, sync_found, trailer_err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 0000", {rx_trailer_st_p, id_rcv_p, sync_found, trailer_err});
        end
        checks++;
        if (sync_errcnt !== 7'd0 || detect_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_counts: errcnt=%0d detect_cnt=%0d expected 0/0", sync_errcnt, detect_cnt);
        end
        rstz = 1'b1;
        @(posedge clk_6M); #1;
    endtask

    task automatic test_exact_match();
        int base;
        id_mode = 1'b0; regi_corr_threshold = 4'd0;
        open_window();
        base = trl_cnt;
        send_word(SW);
        checks++;
        if (trl_cnt !== base) begin
            failures++;
            $display("FAIL exact_early_pulse: pulses=%0d expected %0d", trl_cnt - base, 0);
        end
        send_bit(1'b0);
        checks++;
        if (s_trl !== 1'b1 || s_id !== 1'b0) begin
            failures++;
            $display("FAIL exact_pulse_65: trl=%b id=%b expected 1/0", s_trl, s_id);
        end
        checks++;
        if (sync_errcnt !== 7'd0 || detect_cnt !== 8'd1 || sync_found !== 1'b1) begin
            failures++;
            $display("FAIL exact_state: errcnt=%0d cnt=%0d found=%b expected 0/1/1", sync_errcnt, detect_cnt, sync_found);
        end
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_word(SW); send_bit(1'b0);
        checks++;
        if (trailer_err !== 1'b0 || sync_found !== 1'b1 || trl_cnt !== base + 1 || detect_cnt !== 8'd1) begin
            failures++;
            $display("FAIL exact_locked: terr=%b found=%b pulses=%0d cnt=%0d expected 0/1/1/1", trailer_err, sync_found, trl_cnt - base, detect_cnt);
        end
        close_window();
    endtask

    task automatic test_threshold();
        regi_corr_threshold = 4'd3;
        open_window();
        send_word(SW ^ FLIP);
        send_bit(1'b0);
        checks++;
        if (s_trl !== 1'b1 || sync_errcnt !== 7'd3 || detect_cnt !== 8'd2) begin
            failures++;
            $display("FAIL thr3_detect: trl=%b errcnt=%0d cnt=%0d expected 1/3/2", s_trl, sync_errcnt, detect_cnt);
        end
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        close_window();
        regi_corr_threshold = 4'd2;
        open_window();
        send_word(SW ^ FLIP);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        checks++;
        if (sync_found !== 1'b0 || detect_cnt !== 8'd2 || sync_errcnt !== 7'd3) begin
            failures++;
            $display("FAIL thr2_nodetect: found=%b cnt=%0d errcnt=%0d expected 0/2/3", sync_found, detect_cnt, sync_errcnt);
        end
        close_window();
        regi_corr_threshold = 4'd0;
    endtask

    task automatic test_id_mode();
        logic [19:0] pre;
        int base_t;
        int base_i;
        pre = 20'hA5C3B;
        id_mode = 1'b1;
        open_window();
        base_t = trl_cnt; base_i = id_cnt;
        for (int i = 19; i >= 0; i--) send_bit(pre[i]);
        send_word(SW);
        checks++;
        if (id_cnt !== base_i) begin
            failures++;
            $display("FAIL id_early: pulses=%0d expected 0", id_cnt - base_i);
        end
        send_bit(1'b1);
        checks++;
        if (s_id !== 1'b1 || s_trl !== 1'b0 || sync_found !== 1'b1 || detect_cnt !== 8'd3) begin
            failures++;
            $display("FAIL id_detect: id=%b trl=%b found=%b cnt=%0d expected 1/0/1/3", s_id, s_trl, sync_found, detect_cnt);
        end
        send_word(SW); send_bit(1'b0);
        checks++;
        if (id_cnt !== base_i + 1 || trl_cnt !== base_t || sync_found !== 1'b1 || detect_cnt !== 8'd3) begin
            failures++;
            $display("FAIL id_locked: id=%0d trl=%0d found=%b cnt=%0d expected 1/0/1/3", id_cnt - base_i, trl_cnt - base_t, sync_found, detect_cnt);
        end
        close_window();
        id_mode = 1'b0;
    endtask

    task automatic test_trailer_err();
        open_window();
        send_word(SW);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        checks++;
        if (trailer_err !== 1'b1 || sync_found !== 1'b1 || detect_cnt !== 8'd4) begin
            failures++;
            $display("FAIL trailer_err: terr=%b found=%b cnt=%0d expected 1/1/4", trailer_err, sync_found, detect_cnt);
        end
        send_word(SW); send_bit(1'b0);
        checks++;
        if (trailer_err !== 1'b1 || detect_cnt !== 8'd4) begin
            failures++;
            $display("FAIL trailer_err_hold: terr=%b cnt=%0d expected 1/4", trailer_err, detect_cnt);
        end
        close_window();
    endtask

    task automatic test_abort();
        logic obs;
        open_window();
        send_word(SW);
        p_1us = 1'b1; rxbit = 1'b0; rx_window = 1'b0;
        #2;
        obs = rx_trailer_st_p | id_rcv_p;
        checks++;
        if (obs !== 1'b0) begin
            failures++;
            $display("FAIL abort_window_pulse: got %b expected 0", obs);
        end
        @(posedge clk_6M); #1;
        p_1us = 1'b0;
        checks++;
        if (sync_found !== 1'b0 || detect_cnt !== 8'd4) begin
            failures++;
            $display("FAIL abort_window_state: found=%b cnt=%0d expected 0/4", sync_found, detect_cnt);
        end
        open_window();
        send_word(SW);
        send_bit(1'b0);
        send_bit(1'b0);
        checks++;
        if (sync_found !== 1'b1 || trailer_err !== 1'b1 || detect_cnt !== 8'd5) begin
            failures++;
            $display("FAIL clear_pre: found=%b terr=%b cnt=%0d expected 1/1/5", sync_found, trailer_err, detect_cnt);
        end
        corr_clear = 1'b1;
        @(posedge clk_6M); #1;
        corr_clear = 1'b0;
        checks++;
        if (sync_found !== 1'b0 || trailer_err !== 1'b1 || sync_errcnt !== 7'd0) begin
            failures++;
            $display("FAIL clear_trailer: found=%b terr=%b errcnt=%0d expected 0/1/0", sync_found, trailer_err, sync_errcnt);
        end
        close_window();
    endtask

    task automatic test_saturation();
        gap = 0;
        id_mode = 1'b1;
        for (int n = 0; n < 250; n++) begin
            open_window(); send_word(SW); send_bit(1'b0); close_window();
        end
        checks++;
        if (detect_cnt !== 8'd255) begin
            failures++;
            $display("FAIL sat_reach: cnt=%0d expected 255", detect_cnt);
        end
        open_window(); send_word(SW); send_bit(1'b0);
        checks++;
        if (detect_cnt !== 8'd255 || s_id !== 1'b1) begin
            failures++;
            $display("FAIL sat_hold: cnt=%0d id=%b expected 255/1", detect_cnt, s_id);
        end
        close_window();
        gap = 2;
        id_mode = 1'b0;
    endtask

    task automatic test_reset_mid_search();
        regi_corr_threshold = 4'd3;
        open_window();
        send_word(SW ^ FLIP); send_bit(1'b0);
        close_window();
        open_window();
        for (int i = 0; i < 30; i++) send_bit(SW[63 - i]);
        #1;
        rstz = 1'b0;
        #1;
        checks++;
        if ({rx_trailer_st_p, id_rcv_p, sync_found, trailer_err} !== 4'b0000 ||
            sync_errcnt !== 7'd0 || detect_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_async: flags=%b errcnt=%0d cnt=%0d expected 0000/0/0",
                     {rx_trailer_st_p, id_rcv_p, sync_found, trailer_err}, sync_errcnt, detect_cnt);
        end
        @(posedge clk_6M); #1;
        rstz = 1'b1;
        @(posedge clk_6M); #1;
        regi_corr_threshold = 4'd0;
        send_word(SW);
        checks++;
        if (sync_found !== 1'b0 || detect_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_restart_early: found=%b cnt=%0d expected 0/0", sync_found, detect_cnt);
        end
        send_bit(1'b0);
        checks++;
        if (s_trl !== 1'b1 || detect_cnt !== 8'd1) begin
            failures++;
            $display("FAIL reset_restart: trl=%b cnt=%0d expected 1/1", s_trl, detect_cnt);
        end
        close_window();
    endtask

    initial begin
        test_reset();
        test_exact_match();
        test_threshold();
        test_id_mode();
        test_trailer_err();
        test_abort();
        test_saturation();
        test_reset_mid_search();
        checks++;
        if (both_cnt !== 0) begin
            failures++;
            $display("FAIL pulse_overlap: cycles=%0d expected 0", both_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
